// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes,
// FSM state encoding, alignment rule and byte-lane merge.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } mem_size_t;

    typedef enum logic [0:0] {
        DMR_INIT = 1'b0,
        DMR_RUN  = 1'b1
    } dmr_state_t;

    // SZ_NONE on an active request is treated as a full-word access.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                                input logic [31:0] upd,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = base;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = upd[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_byte_lane_gen.sv
// Turns a store's size and low address bits into byte enables and
// lane-replicated data for the word-organised array.
module byte_lane_gen
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    mem_size_t sz;
    assign sz = mem_size_t'(size);

    always_comb begin
        byte_en    = 4'b1111;
        lane_data  = data;
        misaligned = is_misaligned(sz, addr_lo);
        case (sz)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                lane_data = {4{data[7:0]}};
            end
            SZ_HALF: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{data[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = data;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory for the execute stage: power-up clear, one-entry
// pending write with read forwarding, and alignment/range error pulses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          INIT_CLEAR  = 1'b1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic [31:0] read_address,
    output logic [31:0] DATA_in,
    input  logic        write,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [1:0]  size,
    output logic        ready,
    output logic        err_misaligned,
    output logic        err_range,
    output dmr_state_t  dbg_state
);

    // Handshake: read/write are valid-only strobes with no back-pressure;
    // they are honoured on any posedge where ready=1, otherwise reads return 0
    // and writes are dropped silently.

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [0:0]  ST_INIT    = 1'b0;
    localparam logic [0:0]  ST_RUN     = 1'b1;
    localparam logic [0:0]  ST_RESET   = INIT_CLEAR ? ST_INIT : ST_RUN;

    logic [0:0]       state;
    logic [IDX_W-1:0] init_cnt;
    logic             run;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             pend_valid;
    logic [IDX_W-1:0] pend_idx;
    logic [3:0]       pend_be;
    logic [31:0]      pend_data;

    logic [31:0]      rd_off;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_oor;
    logic             rd_mis;
    logic             rd_bad;
    logic [31:0]      rd_word;

    logic [31:0]      wr_off;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_oor;
    logic             wr_mis;
    logic             wr_bad;
    logic [3:0]       wr_be;
    logic [31:0]      wr_lane;
    logic             wr_accept;

    assign run       = (state == ST_RUN);
    assign ready     = run;
    assign dbg_state = dmr_state_t'(state);

    // Subtraction wraps addresses below BASE_ADDR to large offsets.
    assign rd_off = read_address - BASE_ADDR;
    assign rd_idx = rd_off[IDX_W+1:2];
    assign rd_oor = (rd_off >= SPAN_BYTES);
    assign rd_mis = is_misaligned(mem_size_t'(size), read_address[1:0]);
    assign rd_bad = rd_oor || rd_mis;

    assign wr_off = write_address - BASE_ADDR;
    assign wr_idx = wr_off[IDX_W+1:2];
    assign wr_oor = (wr_off >= SPAN_BYTES);
    assign wr_bad = wr_oor || wr_mis;
    assign wr_accept = run && write && !wr_bad;

    byte_lane_gen u_wr_lanes (
        .size       (size),
        .addr_lo    (write_address[1:0]),
        .data       (write_data),
        .byte_en    (wr_be),
        .lane_data  (wr_lane),
        .misaligned (wr_mis)
    );

    // Read-before-write: a same-cycle store is still on its way into pending,
    // so only the already-pending bytes are merged over the array word.
    always_comb begin
        rd_word = mem[rd_idx];
        if (pend_valid && (pend_idx == rd_idx)) begin
            rd_word = merge_bytes(mem[rd_idx], pend_data, pend_be);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_RESET;
            init_cnt       <= '0;
            pend_valid     <= 1'b0;
            pend_idx       <= '0;
            pend_be        <= '0;
            pend_data      <= '0;
            DATA_in        <= '0;
            err_misaligned <= 1'b0;
            err_range      <= 1'b0;
        end else begin
            err_misaligned <= run && ((read && rd_mis) || (write && wr_mis));
            err_range      <= run && ((read && rd_oor) || (write && wr_oor));

            if (state == ST_INIT) begin
                init_cnt <= init_cnt + IDX_W'(1);
                if (init_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                    state <= ST_RUN;
                end
            end

            if (read) begin
                DATA_in <= (run && !rd_bad) ? rd_word : 32'h0;
            end

            pend_valid <= wr_accept;
            if (wr_accept) begin
                pend_idx  <= wr_idx;
                pend_be   <= wr_be;
                pend_data <= wr_lane;
            end
        end
    end

    // Array has no reset; INIT owns the write port until the clear finishes.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= 32'h0;
        end else if (pend_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (pend_be[i]) mem[pend_idx][i*8 +: 8] <= pend_data[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: INIT timing, table of read/write
// vectors with hand-computed results, and reset during pending/INIT.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] B     = 32'h0000_1000;
    localparam logic [1:0]  SN    = 2'b00;
    localparam logic [1:0]  SB    = 2'b01;
    localparam logic [1:0]  SH    = 2'b10;
    localparam logic [1:0]  SW    = 2'b11;

    logic        clk;
    logic        reset;
    logic        read;
    logic [31:0] read_address;
    logic [31:0] DATA_in;
    logic        write;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic        ready;
    logic        err_misaligned;
    logic        err_range;
    dmr_state_t  dbg_state;

    int n_cmp;
    int n_fail;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        rd;
        logic [31:0] raddr;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  sz;
        logic        chk;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        exp_rng;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (B),
        .INIT_CLEAR  (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .read           (read),
        .read_address   (read_address),
        .DATA_in        (DATA_in),
        .write          (write),
        .write_address  (write_address),
        .write_data     (write_data),
        .size           (size),
        .ready          (ready),
        .err_misaligned (err_misaligned),
        .err_range      (err_range),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d required=done", n_cmp);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        read          = 1'b0;
        read_address  = 32'h0;
        write         = 1'b0;
        write_address = 32'h0;
        write_data    = 32'h0;
        size          = SW;
    endtask

    function automatic vec_t mk(input logic rd, input logic [31:0] raddr,
                                input logic wr, input logic [31:0] waddr,
                                input logic [31:0] wdata, input logic [1:0] sz,
                                input logic chk, input logic [31:0] exp_data,
                                input logic exp_mis, input logic exp_rng);
        vec_t v;
        v.rd = rd; v.raddr = raddr; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
        v.sz = sz; v.chk = chk; v.exp_data = exp_data; v.exp_mis = exp_mis; v.exp_rng = exp_rng;
        return v;
    endfunction

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        int init_cycles;
        int init_noise;

        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        idle_inputs();

        // reset values
        #2;
        check("rst DATA_in", DATA_in, 32'h0);
        check("rst ready", 32'(ready), 32'h0);
        check("rst err_misaligned", 32'(err_misaligned), 32'h0);
        check("rst err_range", 32'(err_range), 32'h0);
        check("rst state", 32'(dbg_state), 32'(DMR_INIT));
        repeat (3) step();
        reset = 1'b1;

        // INIT: hostile requests must be ignored silently
        read = 1'b1; read_address = B + 32'h41; size = SW;
        write = 1'b1; write_address = B + 32'hC; write_data = 32'hFFFF_FFFF;
        init_cycles = 0;
        init_noise  = 0;
        while (!ready && init_cycles < 40) begin
            step();
            init_cycles++;
            if (err_misaligned || err_range || (DATA_in != 32'h0)) init_noise++;
        end
        idle_inputs();
        check("init cycles", 32'(init_cycles), 32'd16);
        check("init quiet", 32'(init_noise), 32'd0);
        check("run state", 32'(dbg_state), 32'(DMR_RUN));

        //            rd  raddr        wr  waddr        wdata          sz  chk exp_data       mis rng
        vecs.push_back(mk(1, B+32'h00,     0, 32'h0,     32'h0,         SW, 1, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(1, B+32'h0C,     0, 32'h0,     32'h0,         SW, 1, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(0, 32'h0,        1, B+32'h08,  32'hDEADBEEF,  SW, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     32'h0,         SW, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, B+32'h08,     0, 32'h0,     32'h0,         SW, 1, 32'hDEADBEEF,  0, 0));
        vecs.push_back(mk(0, 32'h0,        1, B+32'h04,  32'h11223344,  SW, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,        1, B+32'h06,  32'h0000_00AA, SB, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, B+32'h04,     0, 32'h0,     32'h0,         SW, 1, 32'h11AA3344,  0, 0));
        vecs.push_back(mk(1, B+32'h04,     0, 32'h0,     32'h0,         SW, 1, 32'h11AA3344,  0, 0));
        vecs.push_back(mk(0, 32'h0,        1, B+32'h03,  32'h0000_BBBB, SH, 0, 32'h0,         1, 0));
        vecs.push_back(mk(1, B+32'h00,     0, 32'h0,     32'h0,         SW, 1, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(1, B+32'h08,     0, 32'h0,     32'h0,         SW, 1, 32'hDEADBEEF,  0, 0));
        vecs.push_back(mk(1, B+32'h40,     0, 32'h0,     32'h0,         SW, 1, 32'h0000_0000, 0, 1));
        vecs.push_back(mk(1, B+32'h04,     0, 32'h0,     32'h0,         SW, 1, 32'h11AA3344,  0, 0));
        vecs.push_back(mk(1, 32'h0000_0FFC,0, 32'h0,     32'h0,         SW, 1, 32'h0000_0000, 0, 1));
        vecs.push_back(mk(1, B+32'h06,     0, 32'h0,     32'h0,         SH, 1, 32'h11AA3344,  0, 0));
        vecs.push_back(mk(1, B+32'h05,     0, 32'h0,     32'h0,         SH, 1, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(1, B+32'h09,     0, 32'h0,     32'h0,         SB, 1, 32'hDEADBEEF,  0, 0));
        vecs.push_back(mk(1, B+32'h0A,     0, 32'h0,     32'h0,         SN, 1, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(1, B+32'h40,     1, B+32'h02,  32'h99999999,  SW, 1, 32'h0000_0000, 1, 1));
        vecs.push_back(mk(0, 32'h0,        1, B+32'h12,  32'h0000_CAFE, SH, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,        1, B+32'h11,  32'h0000_005A, SB, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, B+32'h10,     1, B+32'h10,  32'h12345678,  SW, 1, 32'hCAFE5A00,  0, 0));
        vecs.push_back(mk(1, B+32'h10,     0, 32'h0,     32'h0,         SW, 1, 32'h12345678,  0, 0));
        vecs.push_back(mk(1, B+32'h10,     0, 32'h0,     32'h0,         SW, 1, 32'h12345678,  0, 0));
        vecs.push_back(mk(0, 32'h0,        1, B+32'h14,  32'hA5A5A5A5,  SN, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     32'h0,         SW, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, B+32'h14,     0, 32'h0,     32'h0,         SW, 1, 32'hA5A5A5A5,  0, 0));
        vecs.push_back(mk(0, 32'h0,        1, B+32'h17,  32'h0000_003C, SB, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     32'h0,         SW, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, B+32'h14,     0, 32'h0,     32'h0,         SW, 1, 32'h3CA5A5A5,  0, 0));
        vecs.push_back(mk(1, B+32'h00,     0, 32'h0,     32'h0,         SW, 1, 32'h0000_0000, 0, 0));

        foreach (vecs[i]) begin
            read          = vecs[i].rd;
            read_address  = vecs[i].raddr;
            write         = vecs[i].wr;
            write_address = vecs[i].waddr;
            write_data    = vecs[i].wdata;
            size          = vecs[i].sz;
            if (vecs[i].chk) exp_q.push_back(vecs[i].exp_data);
            step();
            if (vecs[i].chk) check($sformatf("v%0d DATA_in", i), DATA_in, exp_q.pop_front());
            check($sformatf("v%0d err_misaligned", i), 32'(err_misaligned), 32'(vecs[i].exp_mis));
            check($sformatf("v%0d err_range", i), 32'(err_range), 32'(vecs[i].exp_rng));
        end
        idle_inputs();
        step();
        check("pulse ends mis", 32'(err_misaligned), 32'h0);

        // reset while a write is pending and DATA_in is non-zero
        read = 1'b1; read_address = B + 32'h14; size = SW;
        write = 1'b1; write_address = B + 32'h20; write_data = 32'h7777_7777;
        step();
        idle_inputs();
        check("pre-reset DATA_in", DATA_in, 32'h3CA5A5A5);
        reset = 1'b0;
        #1;
        check("async rst DATA_in", DATA_in, 32'h0);
        check("async rst ready", 32'(ready), 32'h0);
        check("async rst state", 32'(dbg_state), 32'(DMR_INIT));
        repeat (2) step();
        reset = 1'b1;

        // reset again in the middle of INIT; the clear must restart from word 0
        repeat (5) step();
        check("mid-init ready", 32'(ready), 32'h0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        wait_ready(init_cycles);
        check("re-init cycles", 32'(init_cycles), 32'd16);

        read = 1'b1; read_address = B + 32'h20; size = SW;
        step();
        check("pending target cleared", DATA_in, 32'h0);
        read_address = B + 32'h14;
        step();
        check("re-init clear word5", DATA_in, 32'h0);
        read_address = B + 32'h04;
        step();
        check("re-init clear word1", DATA_in, 32'h0);
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
